// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - command FIFO, ALU operand drive and registered result stage
module alu_issue_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_sel,
    input  logic       cmd_fwd,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_zero,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_zero,
    output logic [7:0] issued_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int ENT_W = 12;

    // Entry layout: {a[3:0], b[3:0], sel[2:0], fwd}
    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [3:0]       prev_lo;

    logic             full;
    logic             empty;
    logic             push;
    logic             issue;
    logic [ENT_W-1:0] head;

    assign empty = (wptr == rptr);
    assign full  = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                   (wptr[PTR_W-2:0] == rptr[PTR_W-2:0]);

    // cmd_ready comes only from registered pointers; no bypass when full
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign issue     = !empty && (!res_valid || res_ready);
    assign head      = mem[rptr[AW-1:0]];

    // Operand drive from the FIFO head, forced to zero when nothing is queued
    always_comb begin
        alu_a   = 4'd0;
        alu_b   = 4'd0;
        alu_sel = 3'd0;
        if (!empty) begin
            alu_a   = head[0] ? prev_lo : head[11:8];
            alu_b   = head[7:4];
            alu_sel = head[3:1];
        end
    end

    // Command storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wptr[AW-1:0]] <= {cmd_a, cmd_b, cmd_sel, cmd_fwd};
        end
    end

    // FIFO pointers: push and pop may both happen in one edge
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (issue) begin
                rptr <= rptr + PTR_W'(1);
            end
        end
    end

    // Result register: an issue overwrites (even while draining), a bare drain clears valid
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid  <= 1'b0;
            res_data   <= 8'h00;
            res_zero   <= 1'b0;
            prev_lo    <= 4'h0;
            issued_cnt <= 8'h00;
        end else if (issue) begin
            res_valid  <= 1'b1;
            res_data   <= alu_out;
            res_zero   <= alu_zero;
            prev_lo    <= alu_out[3:0];
            issued_cnt <= issued_cnt + 8'd1;
        end else if (res_valid && res_ready) begin
            res_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_sel;
    logic       cmd_fwd;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_zero;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_zero;
    logic [7:0] issued_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_sel    (cmd_sel),
        .cmd_fwd    (cmd_fwd),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_zero   (res_zero),
        .issued_cnt (issued_cnt)
    );

    // 4-bit combinational ALU seen by the DUT
    always_comb begin
        alu_out = 8'h00;
        case (alu_sel)
            3'b000: alu_out = {4'h0, alu_a} + {4'h0, alu_b};
            3'b001: alu_out = {4'h0, alu_a} - {4'h0, alu_b};
            3'b010: alu_out = {4'h0, alu_a} * {4'h0, alu_b};
            3'b011: alu_out = {4'h0, alu_a & alu_b};
            3'b100: alu_out = {4'h0, alu_a | alu_b};
            3'b101: alu_out = {4'h0, ~alu_a};
            3'b110: alu_out = {4'h0, alu_a} + 8'd1;
            default: alu_out = {4'h0, alu_a} - 8'd1;
        endcase
        alu_zero = (alu_out == 8'h00);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic v, input logic [2:0] sel, input logic [3:0] a,
                           input logic [3:0] b, input logic fwd);
        cmd_valid = v;
        cmd_sel   = sel;
        cmd_a     = a;
        cmd_b     = b;
        cmd_fwd   = fwd;
    endtask

    initial begin
        int k;
        int acc;
        logic was_ready;

        rst       = 1'b1;
        res_ready = 1'b1;
        set_cmd(1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 8'h00);
        check("rst_res_zero", res_zero, 0);
        check("rst_issued_cnt", issued_cnt, 0);
        check("rst_alu_abs", {alu_a, alu_b, alu_sel}, 0);

        // add 5+3: accepted on edge N, issued on N+1
        set_cmd(1'b1, 3'b000, 4'd5, 4'd3, 1'b0);
        step();
        set_cmd(1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
        check("add_alu_a", alu_a, 5);
        check("add_alu_b", alu_b, 3);
        check("add_not_yet_valid", res_valid, 0);
        step();
        check("add_res_valid", res_valid, 1);
        check("add_res_data", res_data, 8'h08);
        check("add_res_zero", res_zero, 0);
        check("add_issued_cnt", issued_cnt, 1);
        step();
        check("add_retired", res_valid, 0);
        check("idle_alu_a", alu_a, 0);

        // Back-to-back subtractions, no bubble
        set_cmd(1'b1, 3'b001, 4'd3, 4'd3, 1'b0);
        step();
        set_cmd(1'b1, 3'b001, 4'd2, 4'd5, 1'b0);
        step();
        set_cmd(1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
        check("sub0_valid", res_valid, 1);
        check("sub0_data", res_data, 8'h00);
        check("sub0_zero", res_zero, 1);
        step();
        check("sub1_valid", res_valid, 1);
        check("sub1_data", res_data, 8'hFD);
        check("sub1_zero", res_zero, 0);
        check("sub_issued_cnt", issued_cnt, 3);
        step();
        check("sub_retired", res_valid, 0);

        // Forwarding: mul 15x15 then add fwd (a ignored) b=1
        set_cmd(1'b1, 3'b010, 4'd15, 4'd15, 1'b0);
        step();
        set_cmd(1'b1, 3'b000, 4'd9, 4'd1, 1'b1);
        step();
        set_cmd(1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
        check("mul_data", res_data, 8'hE1);
        check("fwd_alu_a", alu_a, 4'h1);
        step();
        check("fwd_data", res_data, 8'h02);
        check("fwd_issued_cnt", issued_cnt, 5);
        step();

        // Backpressure: exactly DEPTH+1 accepted, first result held
        res_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            set_cmd(1'b1, 3'b000, 4'(k), 4'd2, 1'b0);
            was_ready = cmd_ready;
            step();
            if (was_ready) k++;
        end
        acc = k;
        set_cmd(1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
        check("bp_accepted", acc, 5);
        check("bp_cmd_ready", cmd_ready, 0);
        check("bp_held_data", res_data, 8'h02);
        step();
        step();
        check("bp_held_stable", res_data, 8'h02);
        check("bp_held_valid", res_valid, 1);
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_drain_valid", res_valid, 1);
            check("bp_drain_data", res_data, 8'(i + 2));
            step();
        end
        check("bp_drain_done", res_valid, 0);
        check("bp_issued_cnt", issued_cnt, 10);

        // Counter wrap
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            set_cmd(1'b1, 3'b110, 4'(i), 4'd0, 1'b0);
            step();
        end
        set_cmd(1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
        check("wrap_cnt_255", issued_cnt, 255);
        step();
        check("wrap_cnt_0", issued_cnt, 0);
        set_cmd(1'b1, 3'b000, 4'd1, 4'd1, 1'b0);
        step();
        set_cmd(1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
        step();
        check("wrap_cnt_1", issued_cnt, 1);
        step();

        // Reset mid-operation, then forwarding sees prev_lo=0
        res_ready = 1'b0;
        set_cmd(1'b1, 3'b000, 4'd3, 4'd4, 1'b0);
        step();
        set_cmd(1'b1, 3'b000, 4'd1, 4'd1, 1'b0);
        step();
        step();
        step();
        set_cmd(1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
        check("mid_res_valid", res_valid, 1);
        check("mid_res_data", res_data, 8'h07);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_cnt", issued_cnt, 0);
        check("mid_rst_alu_a", alu_a, 0);
        res_ready = 1'b1;
        set_cmd(1'b1, 3'b000, 4'd7, 4'd4, 1'b1);
        step();
        set_cmd(1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
        check("post_rst_fwd_a", alu_a, 0);
        step();
        check("post_rst_fwd_data", res_data, 8'h04);
        check("post_rst_fwd_valid", res_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
